// File: rtl/cla_pkg.sv
// Shared constants and helpers for the chunked carry-lookahead adder.
// CHUNK is fixed here so every adder instance uses the same 4-bit CLA cell.
package cla_pkg;

    localparam int CHUNK = 4;

    // Legacy-compatible state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int chunk_count(input int width);
        return width / CHUNK;
    endfunction

endpackage

// File: rtl/cla4_block.sv
// Combinational 4-bit carry-lookahead slice.
// Every carry is a flat sum of products of p/g/c0, so nothing ripples through the slice.
module cla4_block (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4,
    output logic       c3,
    output logic       grp_p,
    output logic       grp_g
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = x ^ y;
    assign g = x & y;

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c4    = grp_g | (grp_p & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA4 slice processes a chunk per cycle,
// with the inter-chunk carry held in a register. Valid/ready on both sides.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N    = chunk_count(WIDTH);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t                     state_q;
    logic [IDXW-1:0]            idx_q;
    logic                       carry_q;
    logic [N-1:0][CHUNK-1:0]    a_q;
    logic [N-1:0][CHUNK-1:0]    b_q;
    logic [N-1:0][CHUNK-1:0]    sum_q;
    logic                       cout_q;
    logic                       ovf_q;

    logic [CHUNK-1:0]           x_c;
    logic [CHUNK-1:0]           y_c;
    logic [CHUNK-1:0]           s_c;
    logic                       c4_c;
    logic                       c3_c;
    logic                       unused_grp_p;
    logic                       unused_grp_g;
    logic                       last_chunk;

    // Chunk select by compare-and-mux keeps index widths exact for any N
    always_comb begin
        x_c = '0;
        y_c = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                x_c = a_q[i];
                y_c = b_q[i];
            end
        end
    end

    cla4_block u_cla4 (
        .x     (x_c),
        .y     (y_c),
        .c0    (carry_q),
        .s     (s_c),
        .c4    (c4_c),
        .c3    (c3_c),
        .grp_p (unused_grp_p),
        .grp_g (unused_grp_g)
    );

    assign last_chunk = (idx_q == IDXW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_q == IDXW'(i)) sum_q[i] <= s_c;
                    end
                    carry_q <= c4_c;
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        cout_q  <= c4_c;
                        // carry into MSB vs carry out of MSB
                        ovf_q   <= c3_c ^ c4_c;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized + directed bench for cla_seq_adder (WIDTH=16 and WIDTH=4 instances)
// against a plain-arithmetic reference model.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    cla_seq_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer addition and sign rules
    function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + 17'(c);
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + 5'(c);
        v = (x[3] == y[3]) && (t[3] != x[3]);
        return {v, t};
    endfunction

    // Wait for out_valid16 after the accept edge; returns cycles counted
    task automatic wait_done16(output int lat);
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic add16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        int          lat;
        logic [17:0] e;
        e = ref16(ta, tb, tc);
        @(negedge clk);
        chk("in_ready16_idle", 32'(in_ready16), 32'd1);
        a16 = ta; b16 = tb; cin16 = tc; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        wait_done16(lat);
        chk("latency16", 32'(lat), 32'd4);
        chk("sum16", 32'(sum16), 32'(e[15:0]));
        chk("cout16", 32'(cout16), 32'(e[16]));
        chk("ovf16", 32'(ovf16), 32'(e[17]));
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        chk("out_valid16_drop", 32'(out_valid16), 32'd0);
    endtask

    task automatic add4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int         lat;
        logic [5:0] e;
        e = ref4(ta, tb, tc);
        @(negedge clk);
        chk("in_ready4_idle", 32'(in_ready4), 32'd1);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency4", 32'(lat), 32'd1);
        chk("sum4", 32'(sum4), 32'(e[3:0]));
        chk("cout4", 32'(cout4), 32'(e[4]));
        chk("ovf4", 32'(ovf4), 32'(e[5]));
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("out_valid4_drop", 32'(out_valid4), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] held;
        logic [17:0] e;

        rst_n = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        in_valid4  = 1'b0; out_ready4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd1);
        chk("rst_sum16", 32'(sum16), 32'd0);
        chk("rst_cout_ovf16", 32'({cout16, ovf16}), 32'd0);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk("rst_sum4", 32'(sum4), 32'd0);

        // Directed cases
        add16(16'h1234, 16'h4321, 1'b0);
        add16(16'hFFFF, 16'h0001, 1'b0);
        add16(16'h7FFF, 16'h0001, 1'b0);
        add16(16'h0000, 16'h0000, 1'b1);
        add16(16'h8000, 16'h8000, 1'b0);

        // Backpressure: result must hold while a new pair is offered
        @(negedge clk);
        a16 = 16'h00FF; b16 = 16'h0101; cin16 = 1'b0; in_valid16 = 1'b1;
        @(negedge clk);
        a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b1;
        wait_done16(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        held = sum16;
        chk("bp_sum", 32'(held), 32'h0200);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_sum", 32'(sum16), 32'h0200);
            chk("bp_hold_valid", 32'(out_valid16), 32'd1);
            chk("bp_in_ready", 32'(in_ready16), 32'd0);
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        chk("bp_back_idle", 32'(in_ready16), 32'd1);
        @(negedge clk);
        in_valid16 = 1'b0;
        e = ref16(16'hABCD, 16'h1111, 1'b1);
        wait_done16(lat);
        chk("bp_new_latency", 32'(lat), 32'd4);
        chk("bp_new_sum", 32'(sum16), 32'(e[15:0]));
        chk("bp_new_cout", 32'(cout16), 32'(e[16]));
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;

        // Reset during the second RUN cycle
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid16), 32'd0);
        chk("midrst_sum", 32'(sum16), 32'd0);
        chk("midrst_in_ready", 32'(in_ready16), 32'd1);
        add16(16'h0F0F, 16'h00F1, 1'b0);

        // Random operands
        repeat (25) add16(16'($urandom), 16'($urandom), 1'($urandom));

        // Single-chunk instance
        add4(4'hF, 4'h1, 1'b1);
        add4(4'h7, 4'h1, 1'b0);
        repeat (10) add4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
